// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES encrypt-round definitions: mode and round-class enums, round
// counts, FSM state encodings, and the forward byte/word primitives
// (S-box word, ShiftRows, MixColumns word, column select/insert).
// State layout: byte i of the FIPS state sits at bits [127-8i -: 8], so
// column c occupies bits [127-32c -: 32].
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        FIRST  = 2'b00,
        MIDDLE = 2'b01,
        FINAL  = 2'b10
    } round_class_e;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SUB  = 3'd1;
    localparam logic [2:0] ST_MIX  = 3'd2;
    localparam logic [2:0] ST_ARK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // What the single-cycle ARK write produces
    localparam logic [1:0] ARK_XOR   = 2'd0;  // state ^ key (round 0)
    localparam logic [1:0] ARK_SHIFT = 2'd1;  // ShiftRows(state) ^ key (final round)
    localparam logic [1:0] ARK_PASS  = 2'd2;  // state unchanged (rejected request)

    // Mode 2'b11 falls through to the AES-256 round count.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            2'b00:   nr = NR_128;
            2'b01:   nr = NR_192;
            default: nr = NR_256;
        endcase
        return nr;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] y;
        p = x;
        y = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            y = gf_mul(y, p);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^
               {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            2'd3:    w = s[31:0];
            default: w = s[127:96];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] idx,
                                             input logic [31:0] w);
        logic [127:0] o;
        o = s;
        case (idx)
            2'd0:    o[127:96] = w;
            2'd1:    o[95:64]  = w;
            2'd2:    o[63:32]  = w;
            2'd3:    o[31:0]   = w;
            default: o = s;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aes_enc_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_enc_round_ctrl
// FSM, 2-bit column counter, round-class decode and valid/ready handshake for
// the sequenced AES encrypt round. Drives the datapath load/write selects.
// Optional build macro AES_ENC_ROUND_CHECK_EN enables rejection of mode=11
// and round>Nr (err=1, data passed through).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid, in_ready    request handshake (in_ready registered)
//   round, mode           request round number and key-size mode
//   out_valid, out_ready  result handshake (out_valid registered)
//   err                   illegal-request flag, held with the result
//   load                  capture data_in/round_key this cycle
//   sub_issue             S-box word consumes column col_sel this cycle
//   mix_en                write MixColumns result for column col_sel
//   ark_en, ark_sel       single-cycle full-state write and its flavour
//   col_sel               current column counter
// -----------------------------------------------------------------------------
module aes_enc_round_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] round,
    input  logic [1:0] mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       load,
    output logic       sub_issue,
    output logic       mix_en,
    output logic       ark_en,
    output logic [1:0] ark_sel,
    output logic [1:0] col_sel
);

    logic [2:0]   state_r, state_nxt_s;
    logic [1:0]   cnt_r, cnt_nxt_s;
    logic         drain_r, drain_nxt_s;
    round_class_e class_r, class_nxt_s, class_s;
    logic [1:0]   ark_sel_r, ark_sel_nxt_s;
    logic         err_r, err_nxt_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         accept_s;
    logic         illegal_s;
    logic [3:0]   nr_s;

    assign accept_s = in_valid & in_ready_r;
    assign nr_s     = nr_of(mode);

`ifdef AES_ENC_ROUND_CHECK_EN
    assign illegal_s = (mode == 2'b11) || (round > nr_s);
`else
    assign illegal_s = 1'b0;
`endif

    // Round-class decode of the request presented at the accept edge
    always_comb begin
        class_s = MIDDLE;
        if (round == 4'd0) begin
            class_s = FIRST;
        end else if (round == nr_s) begin
            class_s = FINAL;
        end else begin
            class_s = MIDDLE;
        end
    end

    // Next-state logic. The S-box word output is registered, so SUB spends
    // one extra drain cycle after issuing column 3 to write it back.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        drain_nxt_s   = drain_r;
        class_nxt_s   = class_r;
        ark_sel_nxt_s = ark_sel_r;
        err_nxt_s     = err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    class_nxt_s = class_s;
                    err_nxt_s   = illegal_s;
                    cnt_nxt_s   = 2'd0;
                    drain_nxt_s = 1'b0;
                    if (illegal_s) begin
                        state_nxt_s   = ST_ARK;
                        ark_sel_nxt_s = ARK_PASS;
                    end else if (class_s == FIRST) begin
                        state_nxt_s   = ST_ARK;
                        ark_sel_nxt_s = ARK_XOR;
                    end else begin
                        state_nxt_s   = ST_SUB;
                        ark_sel_nxt_s = ARK_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SUB: begin
                if (drain_r) begin
                    drain_nxt_s = 1'b0;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = (class_r == FINAL) ? ST_ARK : ST_MIX;
                end else begin
                    cnt_nxt_s   = cnt_r + 2'd1;
                    drain_nxt_s = (cnt_r == 2'd3);
                end
            end
            ST_MIX: begin
                cnt_nxt_s = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MIX;
                end
            end
            ST_ARK: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
                drain_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            drain_r     <= 1'b0;
            class_r     <= MIDDLE;
            ark_sel_r   <= ARK_XOR;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            drain_r     <= drain_nxt_s;
            class_r     <= class_nxt_s;
            ark_sel_r   <= ark_sel_nxt_s;
            err_r       <= err_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;
    assign load      = accept_s;
    assign sub_issue = (state_r == ST_SUB) && !drain_r;
    assign mix_en    = (state_r == ST_MIX);
    assign ark_en    = (state_r == ST_ARK);
    assign ark_sel   = ark_sel_r;
    assign col_sel   = cnt_r;

endmodule

// File: rtl/aes_enc_round_seq.sv
// -----------------------------------------------------------------------------
// aes_enc_round_seq
// Sequenced forward AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// using one 32-bit S-box word and one 32-bit mixword shared over 4 columns.
// Latency from accept edge: round 0 -> 1 cycle, final round -> 6, middle -> 9.
// Optional build macro AES_ENC_ROUND_CHECK_EN: rejects mode=11 / round>Nr with
// err=1 and data_out=data_in; without it err is always 0.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid, in_ready    request handshake
//   round[3:0], mode[1:0] round number and key size (00/01/10 = 128/192/256)
//   round_key[127:0]      round key
//   data_in[127:0]        input state, [127:120] = FIPS byte 0
//   out_valid, out_ready  result handshake
//   data_out[127:0]       round result, same byte order
//   err                   illegal-request flag, qualified by out_valid
// -----------------------------------------------------------------------------
module aes_enc_round_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   round,
    input  logic [1:0]   mode,
    input  logic [127:0] round_key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         err
);

    logic         load_s;
    logic         sub_issue_s;
    logic         mix_en_s;
    logic         ark_en_s;
    logic [1:0]   ark_sel_s;
    logic [1:0]   col_sel_s;

    logic [127:0] state_r;
    logic [127:0] key_r;
    logic [127:0] data_out_r;
    logic [31:0]  sbox_r;
    logic         wb_en_r;
    logic [1:0]   wb_col_r;

    aes_enc_round_ctrl u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .round     (round),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .load      (load_s),
        .sub_issue (sub_issue_s),
        .mix_en    (mix_en_s),
        .ark_en    (ark_en_s),
        .ark_sel   (ark_sel_s),
        .col_sel   (col_sel_s)
    );

    // Working state: captured on accept, columns rewritten in place by the
    // S-box word one cycle after each column is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= 128'h0;
            key_r    <= 128'h0;
            sbox_r   <= 32'h0;
            wb_en_r  <= 1'b0;
            wb_col_r <= 2'd0;
        end else begin
            if (load_s) begin
                state_r <= data_in;
                key_r   <= round_key;
            end else if (wb_en_r) begin
                state_r <= set_col(state_r, wb_col_r, sbox_r);
            end else begin
                state_r <= state_r;
            end
            sbox_r   <= sub_issue_s ? sbox_word(get_col(state_r, col_sel_s)) : sbox_r;
            wb_en_r  <= sub_issue_s;
            wb_col_r <= col_sel_s;
        end
    end

    // Result register: only ARK (whole state) and MIX (one column) write it,
    // so it stays stable while a result waits for out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r <= 128'h0;
        end else if (ark_en_s) begin
            case (ark_sel_s)
                ARK_XOR:   data_out_r <= state_r ^ key_r;
                ARK_SHIFT: data_out_r <= shift_rows(state_r) ^ key_r;
                ARK_PASS:  data_out_r <= state_r;
                default:   data_out_r <= state_r;
            endcase
        end else if (mix_en_s) begin
            data_out_r <= set_col(data_out_r, col_sel_s,
                                  mix_word(get_col(shift_rows(state_r), col_sel_s)) ^
                                  get_col(key_r, col_sel_s));
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign data_out = data_out_r;

endmodule

// File: doc/aes_enc_round_seq.md
Name: aes_enc_round_seq

Overview:
- Sequenced forward AES encryption round for the 128/192/256 datapath; the encrypt-side counterpart of the inverse round used for decryption.
- Processes one 128-bit state per request through SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Uses a single 32-bit S-box word and a single 32-bit mixword, time-shared across 4 columns.
- Sits between the key-schedule/round controller (request side) and the state register or next round (result side); valid/ready on both sides.

Parameters:
- none; all widths fixed by AES (byte 8, word 32, state 128).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block idle, can accept
- round  in  4  round number 0..Nr
- mode  in  2  00 AES-128 (Nr=10), 01 AES-192 (Nr=12), 10 AES-256 (Nr=14), 11 reserved
- round_key  in  128  key for this round
- data_in  in  128  state; data_in[127:120] is FIPS byte 0; column c = bits [127-32c -: 32]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- data_out  out  128  round result, same byte order as data_in
- err  out  1  illegal request flag, qualified by out_valid

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready=1, out_valid=0, data_out=0, err=0, column counter=0, internal state register cleared. Reset mid-operation aborts silently; no partial result is emitted.
- Accept: in_valid & in_ready at edge T. round, mode, round_key and data_in are captured; in_ready drops the next cycle. Inputs are don't-care while busy.
- Round class is decoded from the captured values:
  - FIRST: round=0.
  - FINAL: round=Nr.
  - MIDDLE: otherwise.
- FSM states: IDLE, SUB, MIX, ARK, DONE.
- IDLE:
  - FIRST goes to ARK: data_out = data_in ^ round_key; out_valid at T+1.
  - Otherwise goes to SUB with counter=0.
- SUB (4 cycles):
  - Each cycle, column[counter] passes through the S-box word and is written back in place; counter increments.
  - At counter=3: MIDDLE goes to MIX with counter=0; FINAL goes to ARK.
- MIX (4 cycles, MIDDLE only):
  - Each cycle, column[counter] of ShiftRows(state) goes through mixword and is XORed with round_key column[counter].
  - The result is written to data_out column[counter].
  - At counter=3, go to DONE; out_valid at T+9.
- ARK, FINAL path: data_out = ShiftRows(state) ^ round_key in one cycle; out_valid at T+6.
- DONE:
  - out_valid=1; data_out and err are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid=0, go to IDLE, in_ready=1 the next cycle.
  - No request overlap; a new accept is not possible in the same cycle as the handoff.
- Counter is 2 bits and wraps 3 to 0 at phase change; it never indexes outside columns 0..3.
- data_out changes only in ARK/MIX writes; it is stable from out_valid to the handshake.

Optional Feature:
- Macro: AES_ENC_ROUND_CHECK_EN.
- Defined:
  - mode=11 or round>Nr is illegal.
  - An illegal request goes IDLE to DONE directly: data_out=data_in unchanged, err=1, out_valid at T+1.
  - Legal requests give err=0.
- Undefined:
  - No check; err is tied 0.
  - mode=11 decodes as AES-256.
  - round>Nr is treated as MIDDLE.

Decomposition:
- aes_pkg holds:
  - mode enum (AES128=2'b00, AES192=2'b01, AES256=2'b10)
  - NR_128/NR_192/NR_256 constants
  - round-class enum {FIRST, MIDDLE, FINAL}
  - FSM state enum
  - function nr_of(mode)
- Reuses the existing forward S-box word, forward shiftrow, mixword and addroundkey blocks.
- One new sub-module is natural: aes_enc_round_ctrl, which holds the FSM, column counter, round-class decode and handshake, and drives the datapath selects.

Test Plan:
- FIRST (AES-128 round 0): data_in 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> data_out 00102030405060708090a0b0c0d0e0f0, out_valid at T+1.
- MIDDLE (round 1, mode 00): data_in 00102030405060708090a0b0c0d0e0f0, key d6aa74fdd2af72fadaa678f1d6ab76fe -> 89d810e8855ace682d1843d8cb128fe4 at T+9.
- FINAL (round 10, mode 00): data_in bd6e7c3df2b5779e0b61216e8b10b689, key 13111d7fe3944a17f307a78b4d2b30c5 -> 69c4e0d86a7b0430d8cdb78070b4c55a at T+6. Round 10 with mode 10 must instead take the MIDDLE path (T+9).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> data_out stable, in_ready=0 throughout; a held in_valid is accepted only after the handshake.
- Reset: assert reset_n=0 during SUB cycle 2 -> immediate out_valid=0, data_out=0, in_ready=1; the next request completes with correct data.
- With AES_ENC_ROUND_CHECK_EN: mode=11 or round=11 with mode 00 -> err=1, data_out=data_in at T+1. Without the macro: err is always 0.
